// File: rtl/iq_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iq_rx_pkg
//  Description : Shared definitions for the I/Q receive demodulator.
//                LUT geometry, quarter-wave sine table, cos/-sin lookup
//                helpers used to build the 256-entry LO tables, the sat8
//                clamp and the FIFO write state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package iq_rx_pkg;

    localparam int LUT_WIDTH = 8;
    localparam int LUT_DEPTH = 256;
    localparam int LUT_QTR   = LUT_DEPTH / 4;

    typedef logic signed [LUT_WIDTH-1:0] lut_word_t;

    // round(127*sin(2*pi*k/256)) for k = 0..64; the other three quadrants
    // follow by symmetry.
    localparam lut_word_t SIN_QTR [LUT_QTR+1] = '{
        8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd16,  8'd19,  8'd22,
        8'd25,  8'd28,  8'd31,  8'd34,  8'd37,  8'd40,  8'd43,  8'd46,
        8'd49,  8'd51,  8'd54,  8'd57,  8'd60,  8'd63,  8'd65,  8'd68,
        8'd71,  8'd73,  8'd76,  8'd78,  8'd81,  8'd83,  8'd85,  8'd88,
        8'd90,  8'd92,  8'd94,  8'd96,  8'd98,  8'd100, 8'd102, 8'd104,
        8'd106, 8'd107, 8'd109, 8'd111, 8'd112, 8'd113, 8'd115, 8'd116,
        8'd117, 8'd118, 8'd120, 8'd121, 8'd122, 8'd122, 8'd123, 8'd124,
        8'd125, 8'd125, 8'd126, 8'd126, 8'd126, 8'd127, 8'd127, 8'd127,
        8'd127
    };

    // Full-cycle sine from the quarter table (phase 0..255 = 0..2*pi).
    function automatic lut_word_t sin_lookup(input logic [7:0] p);
        logic [5:0] k;
        k = p[5:0];
        case (p[7:6])
            2'd0:    return SIN_QTR[k];
            2'd1:    return SIN_QTR[7'd64 - {1'b0, k}];
            2'd2:    return -SIN_QTR[k];
            default: return -SIN_QTR[7'd64 - {1'b0, k}];
        endcase
    endfunction

    // cos_lut[p] = round(127*cos(2*pi*p/256))
    function automatic lut_word_t cos_lut(input logic [7:0] p);
        return sin_lookup(p + 8'd64);
    endfunction

    // nsin_lut[p] = -round(127*sin(2*pi*p/256))
    function automatic lut_word_t nsin_lut(input logic [7:0] p);
        return -sin_lookup(p);
    endfunction

    // Clamp a signed value to the signed 8-bit range.
    function automatic logic signed [7:0] sat8(input logic signed [31:0] x);
        if (x > 32'sd127) begin
            return 8'sh7F;
        end else if (x < -32'sd128) begin
            return 8'sh80;
        end else begin
            return x[7:0];
        end
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR_I = 2'd1,
        WR_Q = 2'd2
    } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/iq_demod_if.sv
`default_nettype none
// ============================================================================
//  Module      : iq_demod_if
//  Description : Sample input and FIFO write-side bundle of iq_demod.
//                slave  : the demodulator (consumes samples, writes FIFO)
//                master : the surrounding system / testbench
//  Ports       : en, adc_data, phase   - qualified ADC sample and LO phase
//                fifo_usedw            - FIFO fill level in bytes
//                fifo_data, fifo_wr    - FIFO byte write
//                overflow, ovf_clr     - sticky drop flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
interface iq_demod_if;
    logic        en;
    logic [7:0]  adc_data;
    logic [7:0]  phase;
    logic [11:0] fifo_usedw;
    logic [7:0]  fifo_data;
    logic        fifo_wr;
    logic        overflow;
    logic        ovf_clr;

    modport master (
        output en, adc_data, phase, fifo_usedw, ovf_clr,
        input  fifo_data, fifo_wr, overflow
    );

    modport slave (
        input  en, adc_data, phase, fifo_usedw, ovf_clr,
        output fifo_data, fifo_wr, overflow
    );
endinterface
`default_nettype wire

// File: rtl/trig_lut.sv
`default_nettype none
// ============================================================================
//  Module      : trig_lut
//  Description : Registered dual-output LO ROM, 1-cycle latency.
//                Output registers only load on qualified samples so the
//                tables line up with the registered ADC sample.
//  Ports       : clk     - system clock
//                en_i    - load enable (sample qualifier)
//                phase_i - LO phase, 0..255 = one cycle
//                cos_o   - cos_lut[phase]
//                nsin_o  - nsin_lut[phase]
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_lut
    import iq_rx_pkg::*;
(
    input  logic       clk,
    input  logic       en_i,
    input  logic [7:0] phase_i,
    output lut_word_t  cos_o,
    output lut_word_t  nsin_o
);

    lut_word_t cos_rom  [LUT_DEPTH];
    lut_word_t nsin_rom [LUT_DEPTH];
    lut_word_t cos_q;
    lut_word_t nsin_q;

    // Table contents are constants folded at elaboration.
    for (genvar p = 0; p < LUT_DEPTH; p++) begin : g_rom
        assign cos_rom[p]  = cos_lut(8'(p));
        assign nsin_rom[p] = nsin_lut(8'(p));
    end

    // No reset: block-RAM output registers; validity is tracked upstream.
    always_ff @(posedge clk) begin
        if (en_i) begin
            cos_q  <= cos_rom[phase_i];
            nsin_q <= nsin_rom[phase_i];
        end
    end

    assign cos_o  = cos_q;
    assign nsin_o = nsin_q;

endmodule
`default_nettype wire

// File: rtl/iq_demod.sv
`default_nettype none
// ============================================================================
//  Module      : iq_demod
//  Description : I/Q mixer + integrate-and-dump decimator. Each block of
//                2^DECIM_LOG2 qualified samples produces one I/Q byte pair,
//                written to the FIFO as I then Q, or dropped (sticky
//                overflow) when fewer than two bytes are free.
//  Parameters  : DECIM_LOG2 - log2 decimation ratio (2..12)
//                FIFO_DEPTH - FIFO capacity in bytes
//  Ports       : clk, rst   - system clock, synchronous active-high reset
//                bus        - iq_demod_if.slave (samples in, FIFO out)
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_demod
    import iq_rx_pkg::*;
#(
    parameter int DECIM_LOG2 = 4,
    parameter int FIFO_DEPTH = 4096
) (
    input  logic      clk,
    input  logic      rst,
    iq_demod_if.slave bus
);

    localparam int ACC_W = 16 + DECIM_LOG2;
    localparam int SHIFT = DECIM_LOG2 + 7;
    localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
    localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);

    // ---------------- Stage 1: sample + LO lookup ----------------
    lut_word_t          cos_w;
    lut_word_t          nsin_w;
    logic signed [7:0]  adc_q;
    logic               v1_q;

    trig_lut u_trig_lut (
        .clk     (clk),
        .en_i    (bus.en),
        .phase_i (bus.phase),
        .cos_o   (cos_w),
        .nsin_o  (nsin_w)
    );

    // The valid bit follows en directly so gaps simply flow down the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            adc_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= bus.en;
            if (bus.en) begin
                adc_q <= bus.adc_data;
            end
        end
    end

    // ---------------- Stage 2: multiply ----------------
    logic signed [15:0] prod_ich_q;
    logic signed [15:0] prod_qch_q;
    logic               v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_ich_q <= '0;
            prod_qch_q <= '0;
            v2_q       <= 1'b0;
        end else begin
            v2_q       <= v1_q;
            prod_ich_q <= 16'(adc_q) * 16'(cos_w);
            prod_qch_q <= 16'(adc_q) * 16'(nsin_w);
        end
    end

    // ---------------- Stage 3: integrate and dump ----------------
    logic signed [ACC_W-1:0] acc_ich_q;
    logic signed [ACC_W-1:0] acc_qch_q;
    logic [DECIM_LOG2-1:0]   cnt_q;
    logic signed [7:0]       hold_ich_q;
    logic signed [7:0]       hold_qch_q;
    logic signed [ACC_W-1:0] sum_ich;
    logic signed [ACC_W-1:0] sum_qch;
    logic signed [ACC_W-1:0] shr_ich;
    logic signed [ACC_W-1:0] shr_qch;
    logic                    dump;

    assign sum_ich = acc_ich_q + ACC_W'(prod_ich_q);
    assign sum_qch = acc_qch_q + ACC_W'(prod_qch_q);
    // Arithmetic shift: divides by 2^DECIM_LOG2 samples and 2^7 LUT gain.
    assign shr_ich = sum_ich >>> SHIFT;
    assign shr_qch = sum_qch >>> SHIFT;
    assign dump    = v2_q && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_ich_q  <= '0;
            acc_qch_q  <= '0;
            cnt_q      <= '0;
            hold_ich_q <= '0;
            hold_qch_q <= '0;
        end else if (v2_q) begin
            cnt_q <= cnt_q + CNT_ONE;
            if (dump) begin
                acc_ich_q  <= '0;
                acc_qch_q  <= '0;
                hold_ich_q <= sat8(32'(shr_ich));
                hold_qch_q <= sat8(32'(shr_qch));
            end else begin
                acc_ich_q <= sum_ich;
                acc_qch_q <= sum_qch;
            end
        end
    end

    // ---------------- FIFO write FSM ----------------
    // A dump is at least 4 cycles after the previous one, so the 2-cycle
    // burst is always finished and the FSM sits in IDLE at every dump.
    wr_state_e  state_q;
    wr_state_e  state_d;
    logic       ovf_set;
    logic       room;
    logic       fifo_wr_q;
    logic [7:0] fifo_data_q;
    logic       overflow_q;

    assign room = (int'(bus.fifo_usedw) <= FIFO_DEPTH - 2);

    always_comb begin
        state_d = state_q;
        ovf_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump) begin
                    if (room) begin
                        state_d = WR_I;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            WR_I:    state_d = WR_Q;
            WR_Q:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the state, so the I byte appears the
    // cycle after the state enters WR_I and the Q byte the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= 8'h00;
            overflow_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            fifo_wr_q <= (state_q == WR_I) || (state_q == WR_Q);
            if (state_q == WR_I) begin
                fifo_data_q <= hold_ich_q;
            end else if (state_q == WR_Q) begin
                fifo_data_q <= hold_qch_q;
            end
            // Set has priority over clear.
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.fifo_wr   = fifo_wr_q;
    assign bus.fifo_data = fifo_data_q;
    assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire
